// File: rtl/tick_down_timer.sv
// Programmable down-counting tick timer with one-shot / auto-reload modes and a
// sticky expiry interrupt (irq) with overrun tracking. All outputs are registered.
module tick_down_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         tick_in_i,
  input  logic         start_i,
  input  logic         stop_i,
  input  logic [W-1:0] load_val_i,
  input  logic         reload_i,
  input  logic         irq_ack_i,
  output logic         busy_o,
  output logic [W-1:0] remaining_o,
  output logic         irq_o,
  output logic         overrun_o,
  output logic         err_o
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e       state_q, state_d;
  logic [W-1:0] rem_q, rem_d;
  logic [W-1:0] load_q, load_d;
  logic         reload_q, reload_d;
  logic         irq_q, irq_d;
  logic         overrun_q, overrun_d;
  logic         err_q, err_d;
  logic         expiry;

  // Counting: stop beats start, start beats tick.
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    load_d   = load_q;
    reload_d = reload_q;
    err_d    = 1'b0;
    expiry   = 1'b0;

    if (stop_i) begin
      state_d = StIdle;
      rem_d   = '0;
    end else if (start_i) begin
      if (load_val_i == '0) begin
        err_d = 1'b1;
      end else begin
        state_d  = StRun;
        rem_d    = load_val_i;
        load_d   = load_val_i;
        reload_d = reload_i;
      end
    end else if (tick_in_i && (state_q == StRun)) begin
      if (rem_q == W'(1)) begin
        expiry = 1'b1;
        if (reload_q) begin
          rem_d = load_q;
        end else begin
          rem_d   = '0;
          state_d = StIdle;
        end
      end else begin
        rem_d = rem_q - W'(1);
      end
    end
  end

  // Interrupt handshake: an ack in the same cycle as an expiry consumes only the old event.
  always_comb begin
    irq_d     = irq_q;
    overrun_d = overrun_q;
    if (expiry) begin
      irq_d = 1'b1;
      if (irq_ack_i) begin
        overrun_d = 1'b0;
      end else if (irq_q) begin
        overrun_d = 1'b1;
      end
    end else if (irq_ack_i) begin
      irq_d     = 1'b0;
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      rem_q     <= '0;
      load_q    <= '0;
      reload_q  <= 1'b0;
      irq_q     <= 1'b0;
      overrun_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      load_q    <= load_d;
      reload_q  <= reload_d;
      irq_q     <= irq_d;
      overrun_q <= overrun_d;
      err_q     <= err_d;
    end
  end

  assign busy_o      = (state_q == StRun);
  assign remaining_o = rem_q;
  assign irq_o       = irq_q;
  assign overrun_o   = overrun_q;
  assign err_o       = err_q;

endmodule
